// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the pc_fetch instruction-fetch stage.
// Holds the FSM state encoding, default reset PC and instruction field positions.
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Field positions inside a MIPS instruction word.
    localparam int OPCODE_MSB   = 31;
    localparam int OPCODE_LSB   = 26;
    localparam int FUNCT_MSB    = 5;
    localparam int IMM16_MSB    = 15;
    localparam int TARGET26_MSB = 25;

    localparam int OPCODE_W = OPCODE_MSB - OPCODE_LSB + 1;
    localparam int FUNCT_W  = FUNCT_MSB + 1;

    // Sign-extended word offset of a branch immediate, already scaled to bytes.
    function automatic logic [31:0] branch_offset(input logic [IMM16_MSB:0] imm16);
        return {{14{imm16[IMM16_MSB]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_next_pc_sel.sv
// Combinational next-PC selection: sequential, branch, J and JR targets.
// With FETCH_ALIGN_CHECK_EN defined a misaligned JR target is flagged instead of masked.
module pc_fetch_next_pc_sel
    import pc_fetch_pkg::*;
(
    input  logic [31:0]           pc,
    input  logic [TARGET26_MSB:0] target,
    input  logic                  beq,
    input  logic                  bne,
    input  logic                  j_c,
    input  logic                  jr_c,
    input  logic                  zero,
    input  logic [31:0]           rs_val,
    output logic [31:0]           next_pc,
    output logic [31:0]           pc_plus4,
    output logic                  misalign
);

    logic        taken;
    logic [31:0] jr_target;

    assign pc_plus4 = pc + 32'd4;
    assign taken    = (beq & zero) | (bne & ~zero);

`ifdef FETCH_ALIGN_CHECK_EN
    assign jr_target = rs_val;
    assign misalign  = jr_c & (|rs_val[1:0]);
`else
    // Low address bits of a JR target are dropped rather than trapped.
    logic unused_rs_lsbs;
    assign unused_rs_lsbs = ^rs_val[1:0];
    assign jr_target      = {rs_val[31:2], 2'b00};
    assign misalign       = 1'b0;
`endif

    always_comb begin
        next_pc = pc_plus4;
        if (jr_c) begin
            next_pc = jr_target;
        end else if (j_c) begin
            next_pc = {pc_plus4[31:28], target, 2'b00};
        end else if (taken) begin
            next_pc = pc_plus4 + branch_offset(target[IMM16_MSB:0]);
        end
    end

endmodule

// File: rtl/pc_fetch.sv
// Instruction-fetch / program-counter stage of the single-cycle MIPS core.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned JR halts with sticky fetch_fault).
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        commit,
    input  logic        beq,
    input  logic        bne,
    input  logic        j_c,
    input  logic        jr_c,
    input  logic        zero,
    input  logic [31:0] rs_val,
    output logic        fetch_fault
);

    state_t      state;
    state_t      state_next;
    logic [31:0] next_pc;
    logic        misalign;
    logic        load_instr;
    logic        load_pc;
    logic        set_fault;

    pc_fetch_next_pc_sel u_next_pc_sel (
        .pc       (pc),
        .target   (instr[TARGET26_MSB:0]),
        .beq      (beq),
        .bne      (bne),
        .j_c      (j_c),
        .jr_c     (jr_c),
        .zero     (zero),
        .rs_val   (rs_val),
        .next_pc  (next_pc),
        .pc_plus4 (pc_plus4),
        .misalign (misalign)
    );

    assign imem_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        load_instr  = 1'b0;
        load_pc     = 1'b0;
        set_fault   = 1'b0;
        unique case (state)
            IDLE: begin
                state_next = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    load_instr = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                instr_valid = 1'b1;
                if (commit) begin
                    if (misalign) begin
                        set_fault  = 1'b1;
                        state_next = HALT;
                    end else begin
                        load_pc    = 1'b1;
                        state_next = FETCH;
                    end
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= RESET_PC;
            instr <= '0;
        end else begin
            if (load_pc) begin
                pc <= next_pc;
            end
            if (load_instr) begin
                instr <= imem_rdata;
            end
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    // Sticky until reset so the fault survives the halt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_fault <= 1'b0;
        end else if (set_fault) begin
            fetch_fault <= 1'b1;
        end
    end
`else
    logic unused_fault;
    assign unused_fault = set_fault;
    assign fetch_fault  = 1'b0;
`endif

    // Decoder-facing fields; the opcode/funct split is fixed by the package.
    logic [OPCODE_W-1:0] unused_opcode;
    logic [FUNCT_W-1:0]  unused_funct;
    assign unused_opcode = instr[OPCODE_MSB:OPCODE_LSB];
    assign unused_funct  = instr[FUNCT_MSB:0];

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed cases plus randomized instructions
// checked against a behavioural next-PC model.
module tb_pc_fetch;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        commit;
    logic        beq;
    logic        bne;
    logic        j_c;
    logic        jr_c;
    logic        zero;
    logic [31:0] rs_val;
    logic        fetch_fault;

    int checkCount = 0;
    int errorCount = 0;
    logic [31:0] modelPc;
    bit faultSeen = 0;

    pc_fetch #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .commit      (commit),
        .beq         (beq),
        .bne         (bne),
        .j_c         (j_c),
        .jr_c        (jr_c),
        .zero        (zero),
        .rs_val      (rs_val),
        .fetch_fault (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against the bench's expectation.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural next-PC rule computed from plain arithmetic.
    function automatic logic [31:0] modelNext(input logic [31:0] curPc, input logic [31:0] word,
                                              input logic b, input logic n, input logic j,
                                              input logic jr, input logic z, input logic [31:0] rs);
        logic [31:0] p4;
        logic signed [15:0] imm;
        int off;
        p4 = curPc + 32'd4;
        imm = word[15:0];
        off = imm;
        if (jr) return rs - (rs % 4);
        if (j) return (p4 & 32'hF000_0000) + (word % 32'h0400_0000) * 4;
        if ((b && z) || (n && !z)) return p4 + 32'(off * 4);
        return p4;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clearControls();
        commit = 0; beq = 0; bne = 0; j_c = 0; jr_c = 0; zero = 0; rs_val = '0;
    endtask

    // Fetch one word with the given ack delay, then commit it with the given controls.
    task automatic applyStimulus(input logic [31:0] word, input int delay, input bit spur,
                                 input logic b, input logic n, input logic j,
                                 input logic jr, input logic z, input logic [31:0] rs);
        logic [31:0] expPc;
        bit expFault;
        for (int i = 0; i < delay; i++) begin
            imem_ack = 0;
            imem_rdata = $urandom;
            #1;
            checkOutput("wait_req", {31'd0, imem_req}, 32'd1);
            checkOutput("wait_addr", imem_addr, modelPc);
            checkOutput("wait_valid", {31'd0, instr_valid}, 32'd0);
            tick();
        end
        imem_ack = 1;
        imem_rdata = word;
        #1;
        checkOutput("ack_req", {31'd0, imem_req}, 32'd1);
        checkOutput("ack_addr", imem_addr, modelPc);
        tick();
        imem_ack = 0;
        imem_rdata = $urandom;
        #1;
        checkOutput("exec_valid", {31'd0, instr_valid}, 32'd1);
        checkOutput("exec_req", {31'd0, imem_req}, 32'd0);
        checkOutput("exec_instr", instr, word);
        checkOutput("exec_pc", pc, modelPc);
        checkOutput("pc_plus4", pc_plus4, modelPc + 32'd4);
        if (spur) begin
            imem_ack = 1;
            imem_rdata = ~word;
            tick();
            imem_ack = 0;
            #1;
            checkOutput("spur_instr", instr, word);
            checkOutput("spur_valid", {31'd0, instr_valid}, 32'd1);
        end
        commit = 1; beq = b; bne = n; j_c = j; jr_c = jr; zero = z; rs_val = rs;
`ifdef FETCH_ALIGN_CHECK_EN
        expFault = jr && (rs % 4 != 0);
`else
        expFault = 0;
`endif
        expPc = expFault ? modelPc : modelNext(modelPc, word, b, n, j, jr, z, rs);
        tick();
        commit = 0; beq = $urandom; bne = $urandom; j_c = $urandom; jr_c = $urandom;
        zero = $urandom; rs_val = $urandom;
        #1;
        modelPc = expPc;
        if (expFault) faultSeen = 1;
        checkOutput("commit_pc", pc, modelPc);
        checkOutput("commit_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("commit_fault", {31'd0, fetch_fault}, {31'd0, faultSeen});
        checkOutput("commit_req", {31'd0, imem_req}, expFault ? 32'd0 : 32'd1);
        if (!expFault) checkOutput("commit_addr", imem_addr, modelPc);
        clearControls();
    endtask

    initial begin
        rst = 1; imem_ack = 0; imem_rdata = '0;
        clearControls();
        repeat (3) tick();
        rst = 0;
        modelPc = RST_PC;
        #1;
        checkOutput("rst_req", {31'd0, imem_req}, 32'd0);
        checkOutput("rst_pc", pc, RST_PC);
        checkOutput("rst_instr", instr, 32'd0);
        checkOutput("rst_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("rst_fault", {31'd0, fetch_fault}, 32'd0);
        tick();
        #1;
        checkOutput("first_req", {31'd0, imem_req}, 32'd1);
        checkOutput("first_addr", imem_addr, RST_PC);

        // Three sequential instructions.
        for (int i = 0; i < 3; i++) applyStimulus($urandom, 0, 0, 0, 0, 0, 0, 0, '0);
        checkOutput("seq_pc", modelPc, RST_PC + 32'd12);

        // Branches from 0x100 with imm16 = -2.
        applyStimulus($urandom, 0, 0, 0, 0, 0, 1, 0, 32'h100);
        applyStimulus(32'h1000_FFFE, 0, 0, 1, 0, 0, 0, 1, '0);
        checkOutput("beq_taken", pc, 32'h0FC);
        applyStimulus($urandom, 0, 0, 0, 0, 0, 1, 0, 32'h100);
        applyStimulus(32'h1000_FFFE, 0, 0, 1, 0, 0, 0, 0, '0);
        checkOutput("beq_not_taken", pc, 32'h104);
        applyStimulus($urandom, 0, 0, 0, 0, 0, 1, 0, 32'h100);
        applyStimulus(32'h1400_FFFE, 0, 0, 0, 1, 0, 0, 0, '0);
        checkOutput("bne_taken", pc, 32'h0FC);

        // Jumps.
        applyStimulus($urandom, 0, 0, 0, 0, 0, 1, 0, 32'h1000_0000);
        applyStimulus(32'h0800_0040, 0, 0, 0, 0, 1, 0, 0, '0);
        checkOutput("j_target", pc, 32'h1000_0100);
        applyStimulus(32'h0800_0040, 0, 0, 0, 0, 1, 1, 0, 32'h2000);
        checkOutput("jr_wins", pc, 32'h2000);

        // Slow memory with a spurious ack during execution.
        applyStimulus($urandom, 3, 1, 0, 0, 0, 0, 0, '0);

        // Randomized instruction stream.
        for (int i = 0; i < 60; i++) begin
            logic [31:0] rs;
            rs = $urandom;
`ifdef FETCH_ALIGN_CHECK_EN
            rs[1:0] = 2'b00;
`endif
            applyStimulus($urandom, $urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom),
                          1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                          1'($urandom), rs);
        end

        // Reset pulsed while waiting on memory; ack arriving in IDLE is dropped.
        imem_ack = 0;
        tick();
        rst = 1;
        tick();
        rst = 0;
        imem_ack = 1;
        imem_rdata = 32'hDEAD_BEEF;
        modelPc = RST_PC;
        #1;
        checkOutput("rerst_req", {31'd0, imem_req}, 32'd0);
        checkOutput("rerst_pc", pc, RST_PC);
        tick();
        imem_ack = 0;
        #1;
        checkOutput("rerst_instr", instr, 32'd0);
        checkOutput("rerst_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("rerst_req2", {31'd0, imem_req}, 32'd1);
        checkOutput("rerst_addr", imem_addr, RST_PC);
        applyStimulus($urandom, 1, 0, 0, 0, 0, 0, 0, '0);

        // Misaligned JR target.
        applyStimulus($urandom, 0, 0, 0, 0, 0, 1, 0, 32'h2002);
`ifdef FETCH_ALIGN_CHECK_EN
        for (int i = 0; i < 8; i++) begin
            imem_ack = 1;
            commit = 1;
            tick();
            #1;
            checkOutput("halt_req", {31'd0, imem_req}, 32'd0);
            checkOutput("halt_fault", {31'd0, fetch_fault}, 32'd1);
        end
        checkOutput("halt_pc", pc, modelPc);
        clearControls();
        imem_ack = 0;
`else
        checkOutput("jr_masked", pc, 32'h2000);
        checkOutput("jr_nofault", {31'd0, fetch_fault}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

    // Global time bound so a stuck design still reaches a verdict.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: got running expected finished");
        errorCount++;
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Instruction-fetch and program-counter stage of the single-cycle MIPS core, directly upstream of the main decoder. Holds the PC, fetches each instruction over a req/ack instruction-memory handshake, presents it to the decoder, and on commit computes the next PC from the decoder's branch/jump controls (beq, bne, j_c, jr_c), the ALU zero flag and the register-file rs value.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  core clock, all state on rising edge
- rst  in  1  reset; asynchronous and active-high
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  fetch address (= pc)
- imem_ack  in  1  memory has valid imem_rdata this cycle
- imem_rdata  in  32  instruction word
- instr  out  32  registered instruction to decoder (op_c = [31:26], funct = [5:0])
- instr_valid  out  1  instr is held for execution
- pc  out  32  address of current instruction
- pc_plus4  out  32  pc + 4 (JAL link value)
- commit  in  1  datapath finished current instruction
- beq, bne, j_c, jr_c  in  1 each  decoder controls for current instr
- zero  in  1  ALU zero flag
- rs_val  in  32  register rs value (JR target)
- fetch_fault  out  1  misaligned JR target (see Configuration)

## Operation
- FSM states: IDLE, FETCH, EXEC, HALT.
- IDLE: entered on reset; unconditionally -> FETCH next cycle.
- FETCH: imem_req = 1, imem_addr = pc. On imem_ack: instr <= imem_rdata, -> EXEC. Ack in same cycle as req accepted (zero-wait).
- EXEC: instr_valid = 1, imem_req = 0. On commit: pc <= next_pc, -> FETCH; instr_valid drops.
- next_pc priority: jr_c -> rs_val; else j_c -> {pc_plus4[31:28], instr[25:0], 2'b00}; else taken -> pc_plus4 + (sext(instr[15:0]) << 2); else pc_plus4. taken = (beq & zero) | (bne & ~zero).
- All address arithmetic modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is silent.
- imem_ack outside FETCH ignored; commit outside EXEC ignored.
- Controls (beq, bne, j_c, jr_c, zero, rs_val) sampled only in the commit cycle.
- Reset values: pc = RESET_PC, instr = 0, instr_valid = 0, imem_req = 0, fetch_fault = 0, state = IDLE.
- rst mid-fetch or mid-exec: abandons instruction immediately; stale ack after release ignored (state IDLE).

## Timing
- Reset release at edge E: IDLE during cycle E, imem_req high from cycle E+1.
- Ack in cycle N -> instr_valid high from N+1.
- Commit in cycle M -> new pc and imem_req high in M+1; instr_valid low in M+1.
- Zero-wait memory + same-cycle commit: 2 cycles per instruction.
- imem_addr stable for whole time imem_req is high.
- pc_plus4 combinational from pc.

## Configuration
- FETCH_ALIGN_CHECK_EN defined: on commit with jr_c = 1 and rs_val[1:0] != 0, pc not updated, fetch_fault set (sticky), FSM -> HALT; HALT issues no requests, exits only via rst.
- Undefined: rs_val[1:0] forced to 2'b00 on JR, fetch_fault tied 0, HALT unreachable.

## Structure
- Shared package: FSM state encodings, RESET_PC default, instruction field positions (opcode, funct, imm16, target26).
- Sub-module next_pc_sel: combinational next-PC mux/adders (pc, instr, controls, zero, rs_val -> next_pc, misalign flag); FSM and registers stay in pc_fetch.

## Test plan
- Reset with RESET_PC = 32'h0040_0000, zero-wait ack -> imem_req at cycle 1 after release, imem_addr = 32'h0040_0000, instr_valid next cycle; pc 0x0040_0000 -> 0x0040_0004 -> 0x0040_0008 over three plain commits.
- pc = 0x100, instr imm16 = 16'hFFFE, beq = 1, zero = 1 at commit -> next pc = 0x0FC; same with zero = 0 -> 0x104; bne with zero = 0 -> 0x0FC.
- pc = 0x1000_0000, j_c = 1, instr[25:0] = 26'h0000040 -> next pc = 0x1000_0100; jr_c = 1, j_c = 1, rs_val = 0x2000 -> next pc = 0x2000 (JR wins).
- imem_ack delayed 3 cycles -> imem_req and imem_addr held constant 3 cycles, instr_valid only after ack; spurious ack in EXEC leaves instr unchanged.
- rst pulsed during FETCH wait, ack arrives 1 cycle after release -> ignored, imem_req reasserts with RESET_PC.
- FETCH_ALIGN_CHECK_EN: jr_c = 1, rs_val = 0x2002 -> fetch_fault = 1, imem_req stays 0 indefinitely; without macro -> next pc = 0x2000, fetch_fault = 0.
